svc_mem_sram_arb: RTL

- Two-requester arbiter that shares one zero-latency-read, byte-strobed SRAM port (svc_mem_sram style) between two masters, e.g. instruction fetch (port 0) and load/store (port 1).
- Each master uses a valid/ready request channel and a registered valid/ready response channel.
- Round-robin arbitration, one SRAM access per cycle, fixed one-cycle request-to-response latency.

---
 rtl/svc_mem_sram_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/svc_mem_sram_arb.sv
// svc_mem_sram_arb: two-master arbiter for a single zero-latency, byte-strobed
// SRAM port. Each master has a valid/ready request channel and a registered
// valid/ready response channel with a fixed one-cycle latency.
// Ties are broken round-robin. Defining SVC_MEM_SRAM_ARB_FIXED_PRIO_EN makes
// port 0 always win ties instead, and port 1 can then be starved.
module svc_mem_sram_arb #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic            m0_req_write,
    input  logic [AW-1:0]   m0_req_addr,
    input  logic [DW-1:0]   m0_req_wdata,
    input  logic [DW/8-1:0] m0_req_wstrb,
    output logic            m0_rsp_valid,
    input  logic            m0_rsp_ready,
    output logic [DW-1:0]   m0_rsp_data,

    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic            m1_req_write,
    input  logic [AW-1:0]   m1_req_addr,
    input  logic [DW-1:0]   m1_req_wdata,
    input  logic [DW/8-1:0] m1_req_wstrb,
    output logic            m1_rsp_valid,
    input  logic            m1_rsp_ready,
    output logic [DW-1:0]   m1_rsp_data,

    output logic [AW-1:0]   mem_rd_addr,
    input  logic [DW-1:0]   mem_rd_data,
    output logic [AW-1:0]   mem_wr_addr,
    output logic [DW-1:0]   mem_wr_data,
    output logic [DW/8-1:0] mem_wr_strb,
    output logic            mem_wr_en
);

    // Per-port views of the two masters so the port logic can be generated.
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [1:0]      rsp_ready;
    logic [AW-1:0]   req_addr  [2];
    logic [DW-1:0]   req_wdata [2];
    logic [DW/8-1:0] req_wstrb [2];

    logic            rsp_valid_reg [2];
    logic [DW-1:0]   rsp_data_reg  [2];

    logic [1:0]      eligible;
    logic [1:0]      grant;
    logic            sel;
    logic            any_grant;
    logic            gnt_read;
    logic            gnt_write;

    // Last-driven SRAM addresses, held on cycles that do not use that port.
    logic [AW-1:0]   rd_addr_reg;
    logic [AW-1:0]   wr_addr_reg;

`ifndef SVC_MEM_SRAM_ARB_FIXED_PRIO_EN
    // 1 = port 1 was granted most recently.
    logic            last_grant_reg;
`endif

    assign req_valid    = {m1_req_valid, m0_req_valid};
    assign req_write    = {m1_req_write, m0_req_write};
    assign rsp_ready    = {m1_rsp_ready, m0_rsp_ready};
    assign req_addr[0]  = m0_req_addr;
    assign req_addr[1]  = m1_req_addr;
    assign req_wdata[0] = m0_req_wdata;
    assign req_wdata[1] = m1_req_wdata;
    assign req_wstrb[0] = m0_req_wstrb;
    assign req_wstrb[1] = m1_req_wstrb;

    // A port may only be granted if its response slot is free or being freed now.
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
        assign eligible[gi] = req_valid[gi] && (!rsp_valid_reg[gi] || rsp_ready[gi]);
    end

    // Pick at most one port; nothing is granted while in reset.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (eligible[0] && eligible[1]) begin
`ifdef SVC_MEM_SRAM_ARB_FIXED_PRIO_EN
                grant = 2'b01;
`else
                grant = last_grant_reg ? 2'b01 : 2'b10;
`endif
            end else begin
                grant = eligible;
            end
        end
    end

    assign sel       = grant[1];
    assign any_grant = |grant;
    assign gnt_write = any_grant && req_write[sel];
    assign gnt_read  = any_grant && !req_write[sel];

    assign m0_req_ready = grant[0];
    assign m1_req_ready = grant[1];

    // SRAM side: granted request drives the port, otherwise addresses hold and
    // write data/strobes are forced to zero so the pins stay deterministic.
    assign mem_rd_addr = gnt_read  ? req_addr[sel]  : rd_addr_reg;
    assign mem_wr_addr = gnt_write ? req_addr[sel]  : wr_addr_reg;
    assign mem_wr_data = gnt_write ? req_wdata[sel] : '0;
    assign mem_wr_strb = gnt_write ? req_wstrb[sel] : '0;
    assign mem_wr_en   = gnt_write;

    // Remember last driven addresses and, for round-robin, who won last.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_reg    <= '0;
            wr_addr_reg    <= '0;
`ifndef SVC_MEM_SRAM_ARB_FIXED_PRIO_EN
            last_grant_reg <= 1'b1;
`endif
        end else begin
            if (gnt_read) begin
                rd_addr_reg <= req_addr[sel];
            end
            if (gnt_write) begin
                wr_addr_reg <= req_addr[sel];
            end
`ifndef SVC_MEM_SRAM_ARB_FIXED_PRIO_EN
            if (any_grant) begin
                last_grant_reg <= sel;
            end
`endif
        end
    end

    // Per-port response register: a new grant overrides the accept so a port
    // can stream one access per cycle; otherwise hold until accepted.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_valid_reg[gi] <= 1'b0;
                rsp_data_reg[gi]  <= '0;
            end else if (grant[gi]) begin
                rsp_valid_reg[gi] <= 1'b1;
                rsp_data_reg[gi]  <= req_write[gi] ? '0 : mem_rd_data;
            end else if (rsp_ready[gi]) begin
                rsp_valid_reg[gi] <= 1'b0;
            end
        end
    end

    assign m0_rsp_valid = rsp_valid_reg[0];
    assign m0_rsp_data  = rsp_data_reg[0];
    assign m1_rsp_valid = rsp_valid_reg[1];
    assign m1_rsp_data  = rsp_data_reg[1];

endmodule
